accumulator_sequencer: RTL and testbench
========================================

Name: accumulator_sequencer

Overview:
- Multi-cycle Moore control FSM for the 16-bit accumulator machine (AC, PC, MAR, MBR, IR registers, 16-op ALU, synchronous main memory).
- Runs fetch/decode/execute by driving register write enables, datapath mux selects, the ALU opcode and the memory write strobe.
- Fills the empty control slot between the Register instances and main memory in the top-level computer.

Parameters:
- ADDR_W, 12, width of the IR address/immediate field, instr[ADDR_W-1:0].
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 lets a new instruction fetch start.
- ir_opcode  in  4  IR[15:12], valid from DECODE onward.
- acc_zero  in  1  1 when AC==16'h0000.
- mar_write  out  1  MAR load enable.
- mar_sel  out  1  0: MAR<=PC; 1: MAR<=zero-extended IR address field.
- mbr_write  out  1  MBR load enable.
- mbr_sel  out  1  0: MBR<=mem data_out; 1: MBR<=AC.
- ir_write  out  1  IR<=MBR.
- pc_write  out  1  PC load enable.
- pc_sel  out  1  0: PC<=PC+1 (16'hFFFF wraps to 0); 1: PC<=IR address field.
- acc_write  out  1  AC load enable.
- acc_sel  out  2  0: ALU result; 1: MBR; 2: zero-extended IR immediate.
- alu_opcode  out  4  ALU operation code.
- mem_write  out  1  memory write enable (addr=MAR, data=MBR).
- halted  out  1  sticky; FSM is in HALT.
- illegal  out  1  sticky; halt was caused by a reserved opcode.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Outputs are Moore decodes of the state register. Unlisted strobes are 0; unlisted selects and alu_opcode are 0.
- While reset is low: state=F0; all strobes, selects, alu_opcode, halted, illegal and instr_count are 0.
- Reset is honoured in any state, including mid-instruction. An in-flight mem_write drops immediately.
- Fetch states:
  - F0: if run=1, mar_write=1, mar_sel=0, go to F1. If run=0, assert nothing and stay in F0.
  - F1: memory read cycle, no strobes.
  - F2: mbr_write=1, mbr_sel=0.
  - F3: ir_write=1, pc_write=1, pc_sel=0.
  - Then go to DECODE.
- DECODE: branch on ir_opcode.
  - 0 NOP, A SHL, B SHR, C LOADI, 8 JMP, 9 JZ go to X1.
  - 1 LOAD, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR go to M0.
  - 2 STORE goes to S0.
  - F HALT goes to HALT.
  - D, E go to HALT and set illegal=1.
- X1, one cycle:
  - SHL: acc_write=1, alu_opcode=0100.
  - SHR: acc_write=1, alu_opcode=0101.
  - LOADI: acc_write=1, acc_sel=2.
  - JMP: pc_write=1, pc_sel=1.
  - JZ: pc_write=acc_zero, pc_sel=1.
  - NOP: nothing.
- Memory-operand path:
  - M0: mar_write=1, mar_sel=1.
  - M1: read cycle.
  - M2: mbr_write=1, mbr_sel=0.
  - M3: acc_write=1. LOAD uses acc_sel=1. Others use acc_sel=0 with ALU ops ADD 0000, SUB 0001, AND 1000, OR 1001, XOR 1010.
- STORE path:
  - S0: mar_write=1, mar_sel=1, mbr_write=1, mbr_sel=1.
  - S1: mem_write=1.
- Retire: the last execute state (X1, M3, S1) returns to F0 and increments instr_count by 1, wrapping at all-ones. HALT and illegal opcodes do not count.
- Latency, F0 to next F0 with run=1: X1-class 6 cycles, STORE 7, memory-operand 9.
- ir_opcode is sampled only in DECODE and X1/M3. It is stable because IR is written only in F3.
- HALT: terminal until reset. halted=1, all strobes 0, run is ignored.
- Dropping run mid-instruction does not abort it. The instruction completes and the FSM then waits in F0.

Optional Feature:
- ACCSEQ_SINGLE_STEP_EN defined:
  - Adds input port step (1 bit).
  - A rising edge of step, detected internally and latched as a pending flag, allows exactly one fetch from F0 even when run=0.
  - The flag clears on F0->F1. Reset clears it.
  - run=1 overrides stepping.
- Not defined: no step port; F0 is gated by run only.

Test Plan:
- Reset low mid-M2 of ADD, then release with run=1 -> all strobes 0 and instr_count=0 during reset; mar_write=1, mar_sel=0 on the first cycle after release.
- Program LOADI 5; ADD [0x010] holding 3; STORE [0x011]; HALT, run=1 -> mem[0x011]=8, instr_count=3, halted=1, illegal=0. F0-to-F0 spacings are 6, 9, 7 cycles.
- AC=0, JZ 0x020 -> pc_write=1, pc_sel=1 in X1. Repeat with AC=7 -> pc_write=0 and the PC increments only.
- Opcode 0xD fetched -> halted=1, illegal=1, instr_count unchanged. Asserting run for 50 cycles produces no strobes.
- run=0 held after reset for 20 cycles -> FSM stays in F0, no strobes. run=1 for one cycle during an ADD -> the ADD retires and the FSM waits in F0.
- ACCSEQ_SINGLE_STEP_EN defined, run=0, two step pulses -> exactly 2 instructions retire (instr_count=2), then idle in F0.

Source files
------------

// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer
//   Multi-cycle control FSM for the 16-bit accumulator machine. Sequences
//   fetch, decode and execute by driving the register load enables, datapath
//   mux selects, ALU opcode and memory write strobe.
//
//   Optional feature macro: ACCSEQ_SINGLE_STEP_EN
//     When defined, adds the `step` input. A rising edge on step latches a
//     pending flag that lets one fetch start from F0 even with run=0.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   run          in   level; lets a new fetch start from F0
//   step         in   (ACCSEQ_SINGLE_STEP_EN only) single-step request
//   ir_opcode    in   IR opcode field, valid from DECODE onward
//   acc_zero     in   AC == 0
//   mar_write    out  MAR load; mar_sel 0: PC, 1: IR address field
//   mbr_write    out  MBR load; mbr_sel 0: memory data, 1: AC
//   ir_write     out  IR <= MBR
//   pc_write     out  PC load;  pc_sel 0: PC+1, 1: IR address field
//   acc_write    out  AC load;  acc_sel 0: ALU, 1: MBR, 2: IR immediate
//   alu_opcode   out  ALU operation
//   mem_write    out  memory write (addr=MAR, data=MBR)
//   halted       out  FSM is in HALT
//   illegal      out  halt caused by a reserved opcode
//   instr_count  out  retired-instruction count

module accumulator_sequencer #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
`ifdef ACCSEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [15-ADDR_W:0] ir_opcode,
    input  logic             acc_zero,
    output logic             mar_write,
    output logic             mar_sel,
    output logic             mbr_write,
    output logic             mbr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             acc_write,
    output logic [1:0]       acc_sel,
    output logic [3:0]       alu_opcode,
    output logic             mem_write,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        StF0, StF1, StF2, StF3, StDecode,
        StX1,
        StM0, StM1, StM2, StM3,
        StS0, StS1,
        StHalt
    } state_e;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       op;
    logic             go;

    assign op = 4'(ir_opcode);

`ifdef ACCSEQ_SINGLE_STEP_EN
    logic step_q;
    logic step_pend_q, step_pend_d;

    // Gating with reset keeps every strobe low while reset is asserted.
    assign go = reset & (run | step_pend_q);

    always_comb begin
        step_pend_d = step_pend_q;
        if (state_q == StF0 && go) begin
            step_pend_d = 1'b0;
        end else if (step && !step_q) begin
            step_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_q      <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            step_q      <= step;
            step_pend_q <= step_pend_d;
        end
    end
`else
    assign go = reset & run;
`endif

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        count_d    = count_q;
        mar_write  = 1'b0;
        mar_sel    = 1'b0;
        mbr_write  = 1'b0;
        mbr_sel    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        acc_write  = 1'b0;
        acc_sel    = 2'd0;
        alu_opcode = 4'b0000;
        mem_write  = 1'b0;

        unique case (state_q)
            StF0: begin
                if (go) begin
                    mar_write = 1'b1;
                    state_d   = StF1;
                end
            end
            StF1: state_d = StF2;
            StF2: begin
                mbr_write = 1'b1;
                state_d   = StF3;
            end
            StF3: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = StDecode;
            end
            StDecode: begin
                case (op)
                    4'h0, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC: state_d = StX1;
                    4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state_d = StM0;
                    4'h2:    state_d = StS0;
                    4'hF:    state_d = StHalt;
                    default: begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StX1: begin
                case (op)
                    4'hA: begin
                        acc_write  = 1'b1;
                        alu_opcode = 4'b0100;
                    end
                    4'hB: begin
                        acc_write  = 1'b1;
                        alu_opcode = 4'b0101;
                    end
                    4'hC: begin
                        acc_write = 1'b1;
                        acc_sel   = 2'd2;
                    end
                    4'h8: begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                    end
                    4'h9: begin
                        pc_write = acc_zero;
                        pc_sel   = 1'b1;
                    end
                    default: ;
                endcase
                state_d = StF0;
                count_d = count_q + CNT_W'(1);
            end
            StM0: begin
                mar_write = 1'b1;
                mar_sel   = 1'b1;
                state_d   = StM1;
            end
            StM1: state_d = StM2;
            StM2: begin
                mbr_write = 1'b1;
                state_d   = StM3;
            end
            StM3: begin
                acc_write = 1'b1;
                case (op)
                    4'h1:    acc_sel    = 2'd1;
                    4'h3:    alu_opcode = 4'b0000;
                    4'h4:    alu_opcode = 4'b0001;
                    4'h5:    alu_opcode = 4'b1000;
                    4'h6:    alu_opcode = 4'b1001;
                    4'h7:    alu_opcode = 4'b1010;
                    default: ;
                endcase
                state_d = StF0;
                count_d = count_q + CNT_W'(1);
            end
            StS0: begin
                mar_write = 1'b1;
                mar_sel   = 1'b1;
                mbr_write = 1'b1;
                mbr_sel   = 1'b1;
                state_d   = StS1;
            end
            StS1: begin
                mem_write = 1'b1;
                state_d   = StF0;
                count_d   = count_q + CNT_W'(1);
            end
            StHalt: state_d = StHalt;
            default: state_d = StF0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StF0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign halted      = (state_q == StHalt);
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Bench for accumulator_sequencer: a small datapath (AC/PC/MAR/MBR/IR and a
// synchronous memory) is driven by the DUT's strobes, while an
// instruction-level model predicts every control output on every cycle.

module tb_accumulator_sequencer;

    logic        clock;
    logic        reset;
    logic        run;
`ifdef ACCSEQ_SINGLE_STEP_EN
    logic        step;
    logic        step_drv;
`endif
    logic [3:0]  ir_opcode;
    logic        acc_zero;
    logic        mar_write, mar_sel, mbr_write, mbr_sel, ir_write;
    logic        pc_write, pc_sel, acc_write, mem_write, halted, illegal;
    logic [1:0]  acc_sel;
    logic [3:0]  alu_opcode;
    logic [15:0] instr_count;

    accumulator_sequencer #(.ADDR_W(12), .CNT_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
`ifdef ACCSEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .ir_opcode   (ir_opcode),
        .acc_zero    (acc_zero),
        .mar_write   (mar_write),
        .mar_sel     (mar_sel),
        .mbr_write   (mbr_write),
        .mbr_sel     (mbr_sel),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_sel      (pc_sel),
        .acc_write   (acc_write),
        .acc_sel     (acc_sel),
        .alu_opcode  (alu_opcode),
        .mem_write   (mem_write),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_err;
    int n_checks;
    int cyc;
    int fetch_q[$];

    // ---------------- datapath driven by the DUT ----------------
    logic [15:0] init_mem [4096];
    logic [15:0] dp_mem   [4096];
    logic [15:0] dp_ac, dp_pc, dp_mar, dp_mbr, dp_ir, dp_dout;

    assign ir_opcode = dp_ir[15:12];
    assign acc_zero  = (dp_ac == 16'h0000);

    function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0100: return a << 1;
            4'b0101: return a >> 1;
            4'b1000: return a & b;
            4'b1001: return a | b;
            4'b1010: return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dp_ac   <= 16'h0;
            dp_pc   <= 16'h0;
            dp_mar  <= 16'h0;
            dp_mbr  <= 16'h0;
            dp_ir   <= 16'h0;
            dp_dout <= 16'h0;
            dp_mem  <= init_mem;
        end else begin
            dp_dout <= dp_mem[dp_mar[11:0]];
            if (mar_write) dp_mar <= mar_sel ? {4'h0, dp_ir[11:0]} : dp_pc;
            if (mbr_write) dp_mbr <= mbr_sel ? dp_ac : dp_dout;
            if (ir_write)  dp_ir  <= dp_mbr;
            if (pc_write)  dp_pc  <= pc_sel ? {4'h0, dp_ir[11:0]} : dp_pc + 16'h1;
            if (acc_write) begin
                case (acc_sel)
                    2'd0:    dp_ac <= alu(alu_opcode, dp_ac, dp_mbr);
                    2'd1:    dp_ac <= dp_mbr;
                    2'd2:    dp_ac <= {4'h0, dp_ir[11:0]};
                    default: dp_ac <= dp_ac;
                endcase
            end
            if (mem_write) dp_mem[dp_mar[11:0]] <= dp_mbr;
        end
    end

    // ---------------- instruction-level model ----------------
    // m_p counts cycles since the instruction's F0 (0 = waiting in F0).
    int          m_p;
    logic [3:0]  m_op;
    logic [15:0] m_word, m_pc, m_ac, m_cnt;
    logic        m_halt, m_ill, m_pend, m_step_prev;
    logic [15:0] m_mem [4096];

    // 0: one-cycle execute, 1: memory operand, 2: store, 3: halt/illegal
    function automatic int op_class(input logic [3:0] op);
        case (op)
            4'h0, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC: return 0;
            4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: return 1;
            4'h2:    return 2;
            default: return 3;
        endcase
    endfunction

    // Cycle index of the retiring state: total latency minus one.
    function automatic int last_phase(input logic [3:0] op);
        case (op_class(op))
            0:       return 5;
            1:       return 8;
            default: return 6;
        endcase
    endfunction

    task automatic model_reset();
        m_p = 0; m_op = 4'h0; m_word = 16'h0; m_pc = 16'h0; m_ac = 16'h0;
        m_cnt = 16'h0; m_halt = 1'b0; m_ill = 1'b0; m_pend = 1'b0;
        m_step_prev = 1'b0;
        m_mem = init_mem;
    endtask

    task automatic model_execute();
        logic [11:0] a;
        a = m_word[11:0];
        case (m_op)
            4'hA: m_ac = m_ac << 1;
            4'hB: m_ac = m_ac >> 1;
            4'hC: m_ac = {4'h0, a};
            4'h8: m_pc = {4'h0, a};
            4'h9: if (m_ac == 16'h0) m_pc = {4'h0, a};
            4'h1: m_ac = m_mem[a];
            4'h3: m_ac = m_ac + m_mem[a];
            4'h4: m_ac = m_ac - m_mem[a];
            4'h5: m_ac = m_ac & m_mem[a];
            4'h6: m_ac = m_ac | m_mem[a];
            4'h7: m_ac = m_ac ^ m_mem[a];
            4'h2: m_mem[a] = m_ac;
            default: ;
        endcase
    endtask

    task automatic model_advance();
        logic go, leave;
        leave = 1'b0;
        go = run;
`ifdef ACCSEQ_SINGLE_STEP_EN
        go = go | m_pend;
`endif
        if (!m_halt) begin
            if (m_p == 0) begin
                if (go) begin
                    leave  = 1'b1;
                    m_word = m_mem[m_pc[11:0]];
                    m_op   = m_word[15:12];
                    m_p    = 1;
                end
            end else if (m_p < 3) begin
                m_p++;
            end else if (m_p == 3) begin
                m_pc = m_pc + 16'h1;
                m_p  = 4;
            end else if (m_p == 4) begin
                if (op_class(m_op) == 3) begin
                    m_halt = 1'b1;
                    m_ill  = (m_op != 4'hF);
                end else begin
                    m_p = 5;
                end
            end else if (m_p == last_phase(m_op)) begin
                model_execute();
                m_cnt = m_cnt + 16'h1;
                m_p   = 0;
            end else begin
                m_p++;
            end
        end
`ifdef ACCSEQ_SINGLE_STEP_EN
        if (leave) m_pend = 1'b0;
        else if (step && !m_step_prev) m_pend = 1'b1;
        m_step_prev = step;
`else
        if (leave) m_p = m_p;
`endif
    endtask

    // ---------------- checking ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_outputs();
        logic e_marw, e_mars, e_mbrw, e_mbrs, e_irw, e_pcw, e_pcs, e_accw, e_memw;
        logic e_halt, e_ill, go;
        logic [1:0]  e_accs;
        logic [3:0]  e_alu;
        logic [15:0] e_cnt;
        int cls;
        e_marw = 0; e_mars = 0; e_mbrw = 0; e_mbrs = 0; e_irw = 0; e_pcw = 0;
        e_pcs = 0; e_accw = 0; e_memw = 0; e_halt = 0; e_ill = 0;
        e_accs = 2'd0; e_alu = 4'h0; e_cnt = 16'h0;
        if (reset) begin
            e_cnt  = m_cnt;
            e_ill  = m_ill;
            e_halt = m_halt;
            go = run;
`ifdef ACCSEQ_SINGLE_STEP_EN
            go = go | m_pend;
`endif
            cls = op_class(m_op);
            if (!m_halt) begin
                if (m_p == 0) e_marw = go;
                else if (m_p == 2) e_mbrw = 1;
                else if (m_p == 3) begin e_irw = 1; e_pcw = 1; end
                else if (m_p >= 5 && cls == 0) begin
                    case (m_op)
                        4'hA: begin e_accw = 1; e_alu = 4'b0100; end
                        4'hB: begin e_accw = 1; e_alu = 4'b0101; end
                        4'hC: begin e_accw = 1; e_accs = 2'd2; end
                        4'h8: begin e_pcw = 1; e_pcs = 1; end
                        4'h9: begin e_pcw = (m_ac == 16'h0); e_pcs = 1; end
                        default: ;
                    endcase
                end else if (cls == 1) begin
                    if (m_p == 5) begin e_marw = 1; e_mars = 1; end
                    else if (m_p == 7) e_mbrw = 1;
                    else if (m_p == 8) begin
                        e_accw = 1;
                        case (m_op)
                            4'h1: e_accs = 2'd1;
                            4'h4: e_alu = 4'b0001;
                            4'h5: e_alu = 4'b1000;
                            4'h6: e_alu = 4'b1001;
                            4'h7: e_alu = 4'b1010;
                            default: e_alu = 4'b0000;
                        endcase
                    end
                end else if (cls == 2) begin
                    if (m_p == 5) begin e_marw = 1; e_mars = 1; e_mbrw = 1; e_mbrs = 1; end
                    else if (m_p == 6) e_memw = 1;
                end
            end
        end
        chk1("mar_write", mar_write, e_marw);
        chk1("mar_sel", mar_sel, e_mars);
        chk1("mbr_write", mbr_write, e_mbrw);
        chk1("mbr_sel", mbr_sel, e_mbrs);
        chk1("ir_write", ir_write, e_irw);
        chk1("pc_write", pc_write, e_pcw);
        chk1("pc_sel", pc_sel, e_pcs);
        chk1("acc_write", acc_write, e_accw);
        chk16("acc_sel", {14'h0, acc_sel}, {14'h0, e_accs});
        chk16("alu_opcode", {12'h0, alu_opcode}, {12'h0, e_alu});
        chk1("mem_write", mem_write, e_memw);
        chk1("halted", halted, e_halt);
        chk1("illegal", illegal, e_ill);
        chk16("instr_count", instr_count, e_cnt);
    endtask

    // One clock: apply inputs at the falling edge, check, then step the model
    // across the following rising edge.
    task automatic tick(input logic rst_v, input logic run_v);
        @(negedge clock);
        reset = rst_v;
        run   = run_v;
`ifdef ACCSEQ_SINGLE_STEP_EN
        step  = step_drv;
`endif
        if (!rst_v) model_reset();
        #1;
        compare_outputs();
        if (rst_v && mar_write && !mar_sel) fetch_q.push_back(cyc);
        if (rst_v) model_advance();
        cyc++;
    endtask

    task automatic load_clear();
        for (int i = 0; i < 4096; i++) init_mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        fetch_q.delete();
    endtask

    initial begin
        n_err = 0; n_checks = 0; cyc = 0;
        reset = 1'b0; run = 1'b0;
`ifdef ACCSEQ_SINGLE_STEP_EN
        step = 1'b0; step_drv = 1'b0;
`endif
        load_clear();

        // LOADI 5; ADD [0x010]=3; STORE [0x011]; HALT
        init_mem[0] = 16'hC005; init_mem[1] = 16'h3010;
        init_mem[2] = 16'h2011; init_mem[3] = 16'hF000;
        init_mem['h10] = 16'h0003;
        do_reset();
        repeat (40) tick(1'b1, 1'b1);
        chk16("store_result", dp_mem['h11], 16'h0008);
        chk16("model_store_result", m_mem['h11], 16'h0008);
        chk16("prog_count", instr_count, 16'd3);
        chk1("prog_halted", halted, 1'b1);
        chk1("prog_illegal", illegal, 1'b0);
        chk_int("prog_fetches", fetch_q.size(), 4);
        if (fetch_q.size() >= 4) begin
            chk_int("spacing_loadi", fetch_q[1] - fetch_q[0], 6);
            chk_int("spacing_add", fetch_q[2] - fetch_q[1], 9);
            chk_int("spacing_store", fetch_q[3] - fetch_q[2], 7);
        end

        // Reset in M2 of ADD, then release with run=1.
        do_reset();
        repeat (14) tick(1'b1, 1'b1);
        chk1("in_m2_mbr_write", mbr_write, 1'b1);
        tick(1'b0, 1'b1);
        chk1("rst_mbr_write", mbr_write, 1'b0);
        chk1("rst_mar_write", mar_write, 1'b0);
        chk16("rst_count", instr_count, 16'd0);
        tick(1'b1, 1'b1);
        chk1("release_mar_write", mar_write, 1'b1);
        chk1("release_mar_sel", mar_sel, 1'b0);
        repeat (10) tick(1'b1, 1'b0);

        // JZ taken with AC=0
        load_clear();
        init_mem[0] = 16'hC000; init_mem[1] = 16'h9020; init_mem['h20] = 16'hF000;
        do_reset();
        repeat (30) tick(1'b1, 1'b1);
        chk16("jz_taken_pc", dp_pc, 16'h0021);
        chk16("jz_taken_count", instr_count, 16'd2);

        // JZ not taken with AC=7
        init_mem[0] = 16'hC007; init_mem[2] = 16'hF000;
        do_reset();
        repeat (30) tick(1'b1, 1'b1);
        chk16("jz_fall_pc", dp_pc, 16'h0003);
        chk16("jz_fall_count", instr_count, 16'd2);

        // Reserved opcode, then run held for 50 cycles.
        load_clear();
        init_mem[0] = 16'hD000;
        do_reset();
        repeat (60) tick(1'b1, 1'b1);
        chk1("ill_halted", halted, 1'b1);
        chk1("ill_illegal", illegal, 1'b1);
        chk16("ill_count", instr_count, 16'd0);
        chk_int("ill_fetches", fetch_q.size(), 1);

        // run=0 idle, then a one-cycle run pulse during an ADD.
        load_clear();
        init_mem[0] = 16'h3010; init_mem['h10] = 16'h0001;
        do_reset();
        repeat (20) tick(1'b1, 1'b0);
        chk_int("idle_fetches", fetch_q.size(), 0);
        tick(1'b1, 1'b1);
        repeat (30) tick(1'b1, 1'b0);
        chk16("pulse_count", instr_count, 16'd1);
        chk1("pulse_halted", halted, 1'b0);
        chk_int("pulse_fetches", fetch_q.size(), 1);

`ifdef ACCSEQ_SINGLE_STEP_EN
        // Two step pulses with run=0 retire exactly two NOPs.
        load_clear();
        do_reset();
        step_drv = 1'b1; tick(1'b1, 1'b0);
        step_drv = 1'b0; repeat (10) tick(1'b1, 1'b0);
        step_drv = 1'b1; tick(1'b1, 1'b0);
        step_drv = 1'b0; repeat (30) tick(1'b1, 1'b0);
        chk16("step_count", instr_count, 16'd2);
        chk_int("step_fetches", fetch_q.size(), 2);
`endif

        // Random programs with random run, occasional mid-run resets.
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 4096; i++) begin
                int r;
                logic [3:0] op;
                r = int'($urandom_range(0, 99));
                if (r < 3) op = 4'hF;
                else if (r < 5) op = (r == 3) ? 4'hD : 4'hE;
                else op = 4'($urandom_range(0, 12));
                init_mem[i] = {op, 12'($urandom)};
            end
            do_reset();
            for (int c = 0; c < 300; c++) begin
`ifdef ACCSEQ_SINGLE_STEP_EN
                step_drv = ($urandom_range(0, 3) == 0);
`endif
                tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
